// File: rtl/program_loader_mem.sv
// 256x15 unified memory with a serial program loader that holds the CPU in reset.
// Define PROGRAM_LOADER_CHECKSUM_EN to add the load_csum session checksum port.
module program_loader_mem #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              load_en,
  input  logic              sck,
  input  logic              sdi,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic              cpu_memwrite,
  input  logic [7:0]        cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_reset,
  output logic              load_busy,
  output logic [ADDR_W:0]   load_count
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        load_csum
`endif
);

  typedef enum logic [1:0] {
    RUN, SHIFT, WRITE, RELEASE
  } state_e;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [4:0]      LAST_BIT = 5'(DATA_W);

  state_e              state_q, state_d;
  logic [4:0]          bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] len_q, sck_q, sdi_q;
  logic                sck_prev_q;
  logic                len_s, sdi_s, sck_rise;
  logic                ld_we, cpu_we;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  assign len_s    = len_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_q[SYNC_STAGES-1];
  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_prev_q;

  always_ff @(posedge ph1) begin
    if (reset) begin
      len_q      <= '0;
      sck_q      <= '0;
      sdi_q      <= '0;
      sck_prev_q <= 1'b0;
      state_q    <= RUN;
      bit_q      <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      len_q      <= {len_q[SYNC_STAGES-2:0], load_en};
      sck_q      <= {sck_q[SYNC_STAGES-2:0], sck};
      sdi_q      <= {sdi_q[SYNC_STAGES-2:0], sdi};
      sck_prev_q <= sck_q[SYNC_STAGES-1];
      state_q    <= state_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
    end
  end

  // The 16th rise commits the frame even if load_en falls in the same cycle.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ld_we   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (len_s) begin
          state_d = SHIFT;
          addr_d  = '0;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (sck_rise && bit_q == LAST_BIT) begin
          shift_d = {shift_q[DATA_W-2:0], sdi_s};
          bit_d   = bit_q + 5'd1;
          state_d = WRITE;
        end else if (!len_s) begin
          state_d = RELEASE;
        end else if (sck_rise) begin
          shift_d = {shift_q[DATA_W-2:0], sdi_s};
          bit_d   = bit_q + 5'd1;
        end
      end
      WRITE: begin
        ld_we   = 1'b1;
        addr_d  = addr_q + 1'b1;
        bit_d   = '0;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        state_d = len_s ? SHIFT : RELEASE;
      end
      RELEASE: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign cpu_we = (state_q == RUN) & cpu_memwrite;

  always_ff @(posedge ph1) begin
    if (!reset) begin
      if (ld_we)
        mem_q[addr_q] <= shift_q;
      else if (cpu_we)
        mem_q[cpu_adr][7:0] <= cpu_wdata;
    end
  end

  assign cpu_rdata  = mem_q[cpu_adr];
  assign cpu_reset  = reset | (state_q != RUN);
  assign load_busy  = (state_q != RUN);
  assign load_count = cnt_q;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == RUN && len_s)
      csum_d = '0;
    else if (ld_we)
      csum_d = csum_q + shift_q[7:0] + 8'(shift_q[DATA_W-1:8]);
  end

  always_ff @(posedge ph1) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign load_csum = csum_q;
`endif

endmodule

// File: tb/tb_program_loader_mem.sv
// Directed bench for program_loader_mem: serial loads, wrap, abort, CPU writes.
// Memory expectations flow through a scoreboard queue checked after each session.
module tb_program_loader_mem;

  logic        ph1 = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic [7:0]  cpu_adr = '0;
  logic        cpu_memwrite = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [14:0] cpu_rdata;
  logic        cpu_reset;
  logic        load_busy;
  logic [8:0]  load_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  load_csum;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [7:0]  adr;
    logic [14:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 ph1 = ~ph1;

  program_loader_mem dut (
    .ph1          (ph1),
    .reset        (reset),
    .load_en      (load_en),
    .sck          (sck),
    .sdi          (sdi),
    .cpu_adr      (cpu_adr),
    .cpu_memwrite (cpu_memwrite),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_reset    (cpu_reset),
    .load_busy    (load_busy),
    .load_count   (load_count)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    .load_csum    (load_csum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge ph1);
  endtask

  task automatic send_bits(input logic [15:0] f, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      sdi = f[i];
      sck = 1'b0;
      cyc(4);
      sck = 1'b1;
      cyc(4);
    end
    sck = 1'b0;
  endtask

  task automatic send_frame(input logic [14:0] w);
    send_bits({1'b0, w}, 16);
  endtask

  task automatic start_load(input string tag);
    int n;
    n = 0;
    load_en = 1'b1;
    while (!load_busy && n < 20) begin
      cyc(1);
      n++;
    end
    chk({tag, "_busy"}, load_busy, 1);
    chk({tag, "_cpurst"}, cpu_reset, 1);
  endtask

  // load_en takes two sync stages, then RELEASE holds reset one more cycle.
  task automatic end_load(input string tag);
    cyc(2);
    load_en = 1'b0;
    cyc(3);
    chk({tag, "_release"}, cpu_reset, 1);
    cyc(1);
    chk({tag, "_run"}, cpu_reset, 0);
    chk({tag, "_idle"}, load_busy, 0);
  endtask

  task automatic drain_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cpu_adr = e.adr;
      #1;
      chk(e.tag, cpu_rdata, e.val);
    end
  endtask

  initial begin
    cyc(1);
    chk("rst_cpurst", cpu_reset, 1);
    chk("rst_busy", load_busy, 0);
    chk("rst_count", load_count, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    chk("rst_csum", load_csum, 0);
`endif
    cyc(1);
    chk("rst_cpurst2", cpu_reset, 1);
    reset = 1'b0;
    cyc(1);
    chk("idle_cpurst", cpu_reset, 0);
    chk("idle_busy", load_busy, 0);
    chk("idle_count", load_count, 0);

    start_load("single");
    send_frame(15'h5A3C);
    sb.push_back('{"single_m0", 8'h00, 15'h5A3C});
    chk("single_cpurst_mid", cpu_reset, 1);
    end_load("single");
    chk("single_count", load_count, 1);
    drain_sb();

    start_load("wrap");
    for (int k = 0; k < 257; k++) send_frame(15'(k));
    end_load("wrap");
    chk("wrap_count", load_count, 9'h100);
    sb.push_back('{"wrap_m0", 8'h00, 15'h0100});
    sb.push_back('{"wrap_m1", 8'h01, 15'h0001});
    sb.push_back('{"wrap_m2", 8'h02, 15'h0002});
    sb.push_back('{"wrap_m255", 8'hFF, 15'h00FF});
    drain_sb();

    start_load("part");
    send_frame(15'h1111);
    send_frame(15'h2222);
    send_bits(16'h7FFF, 7);
    end_load("part");
    chk("part_count", load_count, 2);
    sb.push_back('{"part_m0", 8'h00, 15'h1111});
    sb.push_back('{"part_m1", 8'h01, 15'h2222});
    sb.push_back('{"part_m2", 8'h02, 15'h0002});
    sb.push_back('{"part_m3", 8'h03, 15'h0003});
    drain_sb();

    start_load("rstab");
    send_frame(15'h0AAA);
    send_bits(16'h5555, 5);
    reset = 1'b1;
    load_en = 1'b0;
    cyc(1);
    chk("rstab_cpurst", cpu_reset, 1);
    chk("rstab_busy", load_busy, 0);
    chk("rstab_count", load_count, 0);
    reset = 1'b0;
    cyc(2);
    chk("rstab_run", cpu_reset, 0);
    sb.push_back('{"rstab_m0", 8'h00, 15'h0AAA});
    sb.push_back('{"rstab_m1", 8'h01, 15'h2222});
    drain_sb();

    start_load("seed");
    for (int k = 0; k < 17; k++)
      send_frame(k == 16 ? 15'h7F00 : 15'(k));
    end_load("seed");
    chk("seed_count", load_count, 17);
    sb.push_back('{"seed_m10", 8'h10, 15'h7F00});
    drain_sb();

    cpu_adr = 8'h10;
    cpu_wdata = 8'hA5;
    cpu_memwrite = 1'b1;
    cyc(1);
    cpu_memwrite = 1'b0;
    chk("cpuwr_m10", cpu_rdata, 15'h7FA5);

    start_load("blk");
    cpu_adr = 8'h10;
    cpu_wdata = 8'h5A;
    cpu_memwrite = 1'b1;
    cyc(2);
    cpu_memwrite = 1'b0;
    end_load("blk");
    chk("blk_count", load_count, 0);
    sb.push_back('{"blk_m10", 8'h10, 15'h7FA5});
    drain_sb();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    start_load("csum");
    send_frame(15'h7FFF);
    send_frame(15'h0101);
    end_load("csum");
    chk("csum_val", load_csum, 8'h80);
    chk("csum_count", load_count, 2);
    sb.push_back('{"csum_m0", 8'h00, 15'h7FFF});
    sb.push_back('{"csum_m1", 8'h01, 15'h0101});
    drain_sb();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
